// File: rtl/hpi_pkg.sv
// -----------------------------------------------------------------------------
// hpi_pkg
// Shared definitions for the HPI target register block: the register-select
// encoding driven on otg_hpi_address, the STATUS bit positions, and a helper
// that assembles the STATUS word from the individual flags.
// No ports (package).
// -----------------------------------------------------------------------------
package hpi_pkg;

    typedef enum logic [1:0] {
        HPI_DATA    = 2'd0,
        HPI_MAILBOX = 2'd1,
        HPI_ADDR    = 2'd2,
        HPI_STATUS  = 2'd3
    } hpi_reg_e;

    localparam int OUT_FULL = 0;
    localparam int IN_FULL  = 1;
    localparam int ERR      = 2;
    localparam int OVR      = 3;

    // The host sees STATUS as {12'b0, ovr, err, in_full, out_full}.
    function automatic logic [15:0] packStatus(
        input logic ovr,
        input logic err,
        input logic inFull,
        input logic outFull
    );
        logic [15:0] s;
        s           = 16'h0000;
        s[OVR]      = ovr;
        s[ERR]      = err;
        s[IN_FULL]  = inFull;
        s[OUT_FULL] = outFull;
        return s;
    endfunction

endpackage

// File: rtl/hpi_target_if.sv
// -----------------------------------------------------------------------------
// hpi_target_if
// Bundles the host port interface (address, cs/r/w strobes, soft reset,
// 16-bit data in/out) together with the local-side mailbox handshake.
//   master : the SoC host plus the local mailbox user (drives strobes/data,
//            acks the in-mailbox and offers out-mailbox words)
//   slave  : the hpi_target register block
// -----------------------------------------------------------------------------
interface hpi_target_if;

    logic [1:0]  otg_hpi_address;
    logic        otg_hpi_cs_n;
    logic        otg_hpi_r_n;
    logic        otg_hpi_w_n;
    logic        otg_hpi_reset_n;
    logic [15:0] otg_hpi_data_from_host;
    logic [15:0] otg_hpi_data_to_host;

    logic        mbx_in_valid;
    logic [15:0] mbx_in_data;
    logic        mbx_in_ack;
    logic        mbx_out_valid;
    logic [15:0] mbx_out_data;
    logic        mbx_out_ready;

    modport master (
        output otg_hpi_address,
        output otg_hpi_cs_n,
        output otg_hpi_r_n,
        output otg_hpi_w_n,
        output otg_hpi_reset_n,
        output otg_hpi_data_from_host,
        input  otg_hpi_data_to_host,
        input  mbx_in_valid,
        input  mbx_in_data,
        output mbx_in_ack,
        output mbx_out_valid,
        output mbx_out_data,
        input  mbx_out_ready
    );

    modport slave (
        input  otg_hpi_address,
        input  otg_hpi_cs_n,
        input  otg_hpi_r_n,
        input  otg_hpi_w_n,
        input  otg_hpi_reset_n,
        input  otg_hpi_data_from_host,
        output otg_hpi_data_to_host,
        output mbx_in_valid,
        output mbx_in_data,
        input  mbx_in_ack,
        input  mbx_out_valid,
        input  mbx_out_data,
        output mbx_out_ready
    );

endinterface

// File: rtl/hpi_target_ram.sv
// -----------------------------------------------------------------------------
// hpi_target_ram
// Single-port 16-bit word RAM, depth 2^AW, with a registered read port.
// Contents are never reset.
//   clk_i   : clock
//   we_i    : write enable (writes wdata_i to mem[addr_i])
//   re_i    : read enable (captures mem[addr_i] into rdata_o)
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data, holds until the next read
// -----------------------------------------------------------------------------
module hpi_target_ram #(
    parameter int AW = 10
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [15:0]   wdata_i,
    output logic [15:0]   rdata_o
);

    logic [15:0] mem [0:(2**AW)-1];

    // The read register only moves on a read so the host keeps seeing the
    // word it asked for even if later writes hit the same location.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem[addr_i];
        end
    end

endmodule

// File: rtl/hpi_target.sv
// -----------------------------------------------------------------------------
// hpi_target
// Peripheral-side emulation of the 4-register OTG host port interface:
// DATA (auto-incrementing window into an internal RAM), MAILBOX (two-way
// mailbox to local logic), ADDRESS and STATUS.
//   clk_clk       : system clock, rising edge
//   reset_reset_n : asynchronous active-low reset
//   hpi           : host bus + local mailbox handshake (slave modport)
//   hpi_irq       : only with HPI_TARGET_IRQ_EN defined; registered
//                   out_full | ovr
// Optional feature macro: HPI_TARGET_IRQ_EN
// -----------------------------------------------------------------------------
module hpi_target
    import hpi_pkg::*;
#(
    parameter int          AW           = 10,
    parameter logic [15:0] RESET_STATUS = 16'h0000
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    hpi_target_if.slave hpi
`ifdef HPI_TARGET_IRQ_EN
    ,
    output logic        hpi_irq
`endif
);

    localparam logic RST_OUT_FULL = RESET_STATUS[OUT_FULL];
    localparam logic RST_IN_FULL  = RESET_STATUS[IN_FULL];
    localparam logic RST_ERR      = RESET_STATUS[ERR];
    localparam logic RST_OVR      = RESET_STATUS[OVR];

    logic [AW-1:0] addr_q,       addr_d;
    logic          inFull_q,     inFull_d;
    logic          outFull_q,    outFull_d;
    logic          err_q,        err_d;
    logic          ovr_q,        ovr_d;
    logic [15:0]   inData_q,     inData_d;
    logic [15:0]   outData_q,    outData_d;
    logic [15:0]   dataToHost_q, dataToHost_d;
    logic          srcRam_q,     srcRam_d;
    logic          rdHist_q,     rdHist_d;
    logic          wrHist_q,     wrHist_d;

    logic          ramWe;
    logic          ramRe;
    logic [15:0]   ramRdata;

    logic          rdActive;
    logic          wrActive;
    logic          readStart;
    logic          writeStart;
    logic          softReset;
    logic          push;
    hpi_reg_e      regSel;
    logic [15:0]   hostData;

    assign rdActive   = !hpi.otg_hpi_cs_n && !hpi.otg_hpi_r_n;
    assign wrActive   = !hpi.otg_hpi_cs_n && !hpi.otg_hpi_w_n;
    // Both strobes together is a protocol error and never starts an access.
    assign readStart  = rdActive && !wrActive && !rdHist_q;
    assign writeStart = wrActive && !rdActive && !wrHist_q;
    assign softReset  = !hpi.otg_hpi_reset_n;
    assign push       = hpi.mbx_out_valid && !outFull_q;
    assign regSel     = hpi_reg_e'(hpi.otg_hpi_address);
    assign hostData   = hpi.otg_hpi_data_from_host;

    hpi_target_ram #(
        .AW (AW)
    ) u_ram (
        .clk_i   (clk_clk),
        .we_i    (ramWe),
        .re_i    (ramRe),
        .addr_i  (addr_q),
        .wdata_i (hostData),
        .rdata_o (ramRdata)
    );

    // DATA reads come straight from the RAM's read register; every other
    // read is captured in dataToHost_q. srcRam_q picks between them so both
    // paths stay registered and hold until the next read.
    assign hpi.otg_hpi_data_to_host = srcRam_q ? ramRdata : dataToHost_q;
    assign hpi.mbx_in_valid         = inFull_q;
    assign hpi.mbx_in_data          = inData_q;
    assign hpi.mbx_out_ready        = !outFull_q;

    // Next-state logic. Order matters: local ack first, then host actions
    // (a host MAILBOX write overrides a same-cycle ack), then the local push
    // (which can only happen while out_full is clear), and finally the soft
    // reset, which drops everything including any pending RAM write.
    always_comb begin
        addr_d       = addr_q;
        inFull_d     = inFull_q;
        outFull_d    = outFull_q;
        err_d        = err_q;
        ovr_d        = ovr_q;
        inData_d     = inData_q;
        outData_d    = outData_q;
        dataToHost_d = dataToHost_q;
        srcRam_d     = srcRam_q;
        rdHist_d     = rdActive;
        wrHist_d     = wrActive;
        ramWe        = 1'b0;
        ramRe        = 1'b0;

        if (hpi.mbx_in_ack && inFull_q) begin
            inFull_d = 1'b0;
        end

        if (rdActive && wrActive) begin
            err_d = 1'b1;
        end

        if (writeStart) begin
            case (regSel)
                HPI_DATA: begin
                    ramWe  = 1'b1;
                    addr_d = addr_q + AW'(1);
                end
                HPI_MAILBOX: begin
                    inData_d = hostData;
                    inFull_d = 1'b1;
                    if (inFull_q && !hpi.mbx_in_ack) begin
                        ovr_d = 1'b1;
                    end
                end
                HPI_ADDR: begin
                    addr_d = hostData[AW-1:0];
                end
                HPI_STATUS: begin
                    if (hostData[ERR]) err_d = 1'b0;
                    if (hostData[OVR]) ovr_d = 1'b0;
                end
                default: ;
            endcase
        end

        if (readStart) begin
            case (regSel)
                HPI_DATA: begin
                    ramRe    = 1'b1;
                    srcRam_d = 1'b1;
                    addr_d   = addr_q + AW'(1);
                end
                HPI_MAILBOX: begin
                    srcRam_d     = 1'b0;
                    dataToHost_d = outData_q;
                    outFull_d    = 1'b0;
                end
                HPI_ADDR: begin
                    srcRam_d     = 1'b0;
                    dataToHost_d = 16'(addr_q);
                end
                HPI_STATUS: begin
                    srcRam_d     = 1'b0;
                    dataToHost_d = packStatus(ovr_q, err_q, inFull_q, outFull_q);
                end
                default: ;
            endcase
        end

        if (push) begin
            outData_d = hpi.mbx_out_data;
            outFull_d = 1'b1;
        end

        if (softReset) begin
            addr_d       = '0;
            inFull_d     = RST_IN_FULL;
            outFull_d    = RST_OUT_FULL;
            err_d        = RST_ERR;
            ovr_d        = RST_OVR;
            inData_d     = 16'h0000;
            outData_d    = 16'h0000;
            dataToHost_d = 16'h0000;
            srcRam_d     = 1'b0;
            rdHist_d     = 1'b0;
            wrHist_d     = 1'b0;
            ramWe        = 1'b0;
            ramRe        = 1'b0;
        end
    end

    // State register with the asynchronous board reset.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            addr_q       <= '0;
            inFull_q     <= RST_IN_FULL;
            outFull_q    <= RST_OUT_FULL;
            err_q        <= RST_ERR;
            ovr_q        <= RST_OVR;
            inData_q     <= 16'h0000;
            outData_q    <= 16'h0000;
            dataToHost_q <= 16'h0000;
            srcRam_q     <= 1'b0;
            rdHist_q     <= 1'b0;
            wrHist_q     <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            inFull_q     <= inFull_d;
            outFull_q    <= outFull_d;
            err_q        <= err_d;
            ovr_q        <= ovr_d;
            inData_q     <= inData_d;
            outData_q    <= outData_d;
            dataToHost_q <= dataToHost_d;
            srcRam_q     <= srcRam_d;
            rdHist_q     <= rdHist_d;
            wrHist_q     <= wrHist_d;
        end
    end

`ifdef HPI_TARGET_IRQ_EN
    logic irq_q;

    // Interrupt follows out_full | ovr with one cycle of delay.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= outFull_q || ovr_q;
        end
    end

    assign hpi_irq = irq_q;
`endif

endmodule

// File: tb/tb_hpi_target.sv
// -----------------------------------------------------------------------------
// tb_hpi_target
// Directed bench for hpi_target. Host reads push their expected word into a
// queue; a monitor watching the bus for read starts pops and compares the
// returned data one cycle later. Sideband signals are checked directly.
// Honors HPI_TARGET_IRQ_EN when defined.
// -----------------------------------------------------------------------------
module tb_hpi_target;
    import hpi_pkg::*;

    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_BOTH} opKind_e;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [15:0] expQ [$];

`ifdef HPI_TARGET_IRQ_EN
    logic hpiIrq;
`endif

    hpi_target_if bus ();

    hpi_target #(
        .AW           (10),
        .RESET_STATUS (16'h0000)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .hpi           (bus.slave)
`ifdef HPI_TARGET_IRQ_EN
        ,
        .hpi_irq       (hpiIrq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; every check funnels through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
        end
    endtask

    // One host access. Strobes go active just after a rising edge and stay
    // for 'hold' rising edges. Reads queue their expected data first.
    task automatic applyStimulus(input opKind_e op, input logic [1:0] sel,
                                 input logic [15:0] data, input int hold = 1,
                                 input logic [15:0] expRd = 16'h0,
                                 input bit withAck = 1'b0);
        if (op == OP_READ) expQ.push_back(expRd);
        @(posedge clk); #1;
        bus.otg_hpi_address        = sel;
        bus.otg_hpi_data_from_host = data;
        bus.otg_hpi_cs_n           = 1'b0;
        bus.mbx_in_ack             = withAck;
        if (op == OP_READ || op == OP_BOTH)  bus.otg_hpi_r_n = 1'b0;
        if (op == OP_WRITE || op == OP_BOTH) bus.otg_hpi_w_n = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        bus.otg_hpi_cs_n = 1'b1;
        bus.otg_hpi_r_n  = 1'b1;
        bus.otg_hpi_w_n  = 1'b1;
        bus.mbx_in_ack   = 1'b0;
    endtask

    // Read monitor: spots each read strobe assertion on the bus and checks
    // data_to_host on the following cycle against the queued expectation.
    initial begin : monitor
        logic        prevRd;
        logic        pending;
        logic        active;
        logic [15:0] want;
        prevRd  = 1'b0;
        pending = 1'b0;
        want    = 16'h0;
        forever begin
            @(negedge clk);
            if (pending) begin
                checkOutput("readData", {16'h0, bus.otg_hpi_data_to_host}, {16'h0, want});
                pending = 1'b0;
            end
            if (!rst_n || !bus.otg_hpi_reset_n) begin
                prevRd = 1'b0;
            end else begin
                active = !bus.otg_hpi_cs_n && !bus.otg_hpi_r_n;
                if (active && bus.otg_hpi_w_n && !prevRd) begin
                    if (expQ.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpectedRead: got read start want none");
                    end else begin
                        want    = expQ.pop_front();
                        pending = 1'b1;
                    end
                end
                prevRd = active;
            end
        end
    end

    initial begin : stimulus
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.otg_hpi_address        = 2'd0;
        bus.otg_hpi_cs_n           = 1'b1;
        bus.otg_hpi_r_n            = 1'b1;
        bus.otg_hpi_w_n            = 1'b1;
        bus.otg_hpi_reset_n        = 1'b1;
        bus.otg_hpi_data_from_host = 16'h0;
        bus.mbx_in_ack             = 1'b0;
        bus.mbx_out_valid          = 1'b0;
        bus.mbx_out_data           = 16'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] reset state");
        @(negedge clk);
        checkOutput("rstDataToHost", {16'h0, bus.otg_hpi_data_to_host}, 32'h0);
        checkOutput("rstInValid", {31'h0, bus.mbx_in_valid}, 32'h0);
        checkOutput("rstOutReady", {31'h0, bus.mbx_out_ready}, 32'h1);
`ifdef HPI_TARGET_IRQ_EN
        checkOutput("rstIrq", {31'h0, hpiIrq}, 32'h0);
`endif
        applyStimulus(OP_READ, HPI_STATUS, 16'h0, 1, 16'h0000);
        applyStimulus(OP_READ, HPI_ADDR, 16'h0, 1, 16'h0000);

        $display("[TB] auto-increment write/read");
        applyStimulus(OP_WRITE, HPI_ADDR, 16'h0005);
        applyStimulus(OP_WRITE, HPI_DATA, 16'h1111);
        applyStimulus(OP_WRITE, HPI_DATA, 16'h2222);
        applyStimulus(OP_WRITE, HPI_ADDR, 16'h0005);
        applyStimulus(OP_READ, HPI_DATA, 16'h0, 1, 16'h1111);
        applyStimulus(OP_READ, HPI_DATA, 16'h0, 1, 16'h2222);
        applyStimulus(OP_READ, HPI_ADDR, 16'h0, 1, 16'h0007);

        $display("[TB] address wrap");
        applyStimulus(OP_WRITE, HPI_ADDR, 16'hFFFF);
        applyStimulus(OP_READ, HPI_ADDR, 16'h0, 1, 16'h03FF);
        applyStimulus(OP_WRITE, HPI_DATA, 16'hBEEF);
        applyStimulus(OP_READ, HPI_ADDR, 16'h0, 1, 16'h0000);
        applyStimulus(OP_WRITE, HPI_ADDR, 16'h03FF);
        applyStimulus(OP_READ, HPI_DATA, 16'h0, 1, 16'hBEEF);
        applyStimulus(OP_READ, HPI_ADDR, 16'h0, 1, 16'h0000);

        $display("[TB] host-to-local mailbox");
        applyStimulus(OP_WRITE, HPI_MAILBOX, 16'hA5A5);
        @(negedge clk);
        checkOutput("inValidSet", {31'h0, bus.mbx_in_valid}, 32'h1);
        checkOutput("inData", {16'h0, bus.mbx_in_data}, 32'h0000A5A5);
        applyStimulus(OP_READ, HPI_STATUS, 16'h0, 1, 16'h0002);
        applyStimulus(OP_WRITE, HPI_MAILBOX, 16'h5A5A);
        applyStimulus(OP_READ, HPI_STATUS, 16'h0, 1, 16'h000A);
        @(negedge clk);
        checkOutput("inDataOvr", {16'h0, bus.mbx_in_data}, 32'h00005A5A);
        @(posedge clk); #1 bus.mbx_in_ack = 1'b1;
        @(posedge clk); #1 bus.mbx_in_ack = 1'b0;
        @(negedge clk);
        checkOutput("inValidAcked", {31'h0, bus.mbx_in_valid}, 32'h0);
        applyStimulus(OP_WRITE, HPI_STATUS, 16'h0008);
        applyStimulus(OP_READ, HPI_STATUS, 16'h0, 1, 16'h0000);
        applyStimulus(OP_WRITE, HPI_MAILBOX, 16'h1111);
        applyStimulus(OP_WRITE, HPI_MAILBOX, 16'h2222, 1, 16'h0, 1'b1);
        applyStimulus(OP_READ, HPI_STATUS, 16'h0, 1, 16'h0002);
        @(negedge clk);
        checkOutput("inDataAckRace", {16'h0, bus.mbx_in_data}, 32'h00002222);
        @(posedge clk); #1 bus.mbx_in_ack = 1'b1;
        @(posedge clk); #1 bus.mbx_in_ack = 1'b1;
        @(posedge clk); #1 bus.mbx_in_ack = 1'b0;
        applyStimulus(OP_READ, HPI_STATUS, 16'h0, 1, 16'h0000);

        $display("[TB] local-to-host mailbox");
        @(posedge clk); #1;
        bus.mbx_out_valid = 1'b1;
        bus.mbx_out_data  = 16'h1234;
        @(negedge clk);
        checkOutput("outReadyEmpty", {31'h0, bus.mbx_out_ready}, 32'h1);
        @(posedge clk); #1 bus.mbx_out_valid = 1'b0;
        @(negedge clk);
        checkOutput("outReadyFull", {31'h0, bus.mbx_out_ready}, 32'h0);
        @(negedge clk);
`ifdef HPI_TARGET_IRQ_EN
        checkOutput("irqSet", {31'h0, hpiIrq}, 32'h1);
`endif
        applyStimulus(OP_READ, HPI_STATUS, 16'h0, 1, 16'h0001);
        applyStimulus(OP_READ, HPI_MAILBOX, 16'h0, 1, 16'h1234);
        @(negedge clk);
        checkOutput("outReadyDrained", {31'h0, bus.mbx_out_ready}, 32'h1);
        @(negedge clk);
`ifdef HPI_TARGET_IRQ_EN
        checkOutput("irqClear", {31'h0, hpiIrq}, 32'h0);
`endif
        @(posedge clk); #1;
        bus.mbx_out_valid = 1'b1;
        bus.mbx_out_data  = 16'h5678;
        @(posedge clk); #1 bus.mbx_out_valid = 1'b0;
        applyStimulus(OP_READ, HPI_MAILBOX, 16'h0, 1, 16'h5678);
        applyStimulus(OP_READ, HPI_STATUS, 16'h0, 1, 16'h0000);

        $display("[TB] strobe conflict and held strobe");
        applyStimulus(OP_WRITE, HPI_ADDR, 16'h0010);
        applyStimulus(OP_BOTH, HPI_ADDR, 16'h0033);
        applyStimulus(OP_READ, HPI_STATUS, 16'h0, 1, 16'h0004);
        applyStimulus(OP_READ, HPI_ADDR, 16'h0, 1, 16'h0010);
        applyStimulus(OP_WRITE, HPI_STATUS, 16'h0004);
        applyStimulus(OP_READ, HPI_STATUS, 16'h0, 1, 16'h0000);
        applyStimulus(OP_WRITE, HPI_DATA, 16'h7777);
        applyStimulus(OP_WRITE, HPI_ADDR, 16'h0010);
        applyStimulus(OP_READ, HPI_DATA, 16'h0, 5, 16'h7777);
        applyStimulus(OP_READ, HPI_ADDR, 16'h0, 1, 16'h0011);

        $display("[TB] soft reset");
        applyStimulus(OP_WRITE, HPI_ADDR, 16'h0000);
        applyStimulus(OP_WRITE, HPI_DATA, 16'h0BAD);
        applyStimulus(OP_WRITE, HPI_ADDR, 16'h0042);
        applyStimulus(OP_WRITE, HPI_DATA, 16'hCAFE);
        applyStimulus(OP_WRITE, HPI_ADDR, 16'h0042);
        applyStimulus(OP_WRITE, HPI_MAILBOX, 16'h9999);
        @(negedge clk);
        checkOutput("inValidPreReset", {31'h0, bus.mbx_in_valid}, 32'h1);
        @(posedge clk); #1 bus.otg_hpi_reset_n = 1'b0;
        @(posedge clk); #1 bus.otg_hpi_reset_n = 1'b1;
        @(negedge clk);
        checkOutput("softRstInValid", {31'h0, bus.mbx_in_valid}, 32'h0);
        checkOutput("softRstDataToHost", {16'h0, bus.otg_hpi_data_to_host}, 32'h0);
        applyStimulus(OP_READ, HPI_STATUS, 16'h0, 1, 16'h0000);
        applyStimulus(OP_READ, HPI_ADDR, 16'h0, 1, 16'h0000);
        applyStimulus(OP_WRITE, HPI_ADDR, 16'h0042);

        // DATA read held across a soft reset: one read before, a fresh one
        // after release (from address 0, which then advances to 1).
        expQ.push_back(16'hCAFE);
        expQ.push_back(16'h0BAD);
        @(posedge clk); #1;
        bus.otg_hpi_address = HPI_DATA;
        bus.otg_hpi_cs_n    = 1'b0;
        bus.otg_hpi_r_n     = 1'b0;
        @(posedge clk); #1 bus.otg_hpi_reset_n = 1'b0;
        @(posedge clk); #1 bus.otg_hpi_reset_n = 1'b1;
        @(posedge clk); #1;
        bus.otg_hpi_cs_n = 1'b1;
        bus.otg_hpi_r_n  = 1'b1;
        applyStimulus(OP_READ, HPI_ADDR, 16'h0, 1, 16'h0001);

        $display("[TB] asynchronous reset");
        applyStimulus(OP_WRITE, HPI_MAILBOX, 16'h0001);
        applyStimulus(OP_READ, HPI_STATUS, 16'h0, 1, 16'h0002);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncRstDataToHost", {16'h0, bus.otg_hpi_data_to_host}, 32'h0);
        checkOutput("asyncRstInValid", {31'h0, bus.mbx_in_valid}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        applyStimulus(OP_READ, HPI_STATUS, 16'h0, 1, 16'h0000);

        repeat (4) @(negedge clk);
        checkOutput("scoreboardDrained", 32'(expQ.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hpi_target.md
Name: hpi_target

Overview:
- Register-level responder for the 4-register OTG host port interface the SoC drives through its PIO exports (address[1:0], cs, r, w, reset, 16-bit data in/out).
- Emulates the peripheral side: DATA, MAILBOX, ADDRESS and STATUS registers, an internal 16-bit word RAM with auto-incrementing address, and a two-way mailbox to local logic.
- Lets the NIOS HPI driver run and be verified on-chip without the external USB controller.

Parameters:
- AW, 10, internal RAM address width; RAM depth is 2^AW words of 16 bits.
- RESET_STATUS, 16'h0000, STATUS value after either reset.

Ports:
- clk_clk  in  1  system clock; all logic on its rising edge.
- reset_reset_n  in  1  asynchronous, active-low reset.
- otg_hpi_address  in  2  register select: 0=DATA, 1=MAILBOX, 2=ADDRESS, 3=STATUS.
- otg_hpi_cs_n  in  1  chip select, active low.
- otg_hpi_r_n  in  1  read strobe, active low.
- otg_hpi_w_n  in  1  write strobe, active low.
- otg_hpi_reset_n  in  1  soft reset from host, active low, sampled synchronously.
- otg_hpi_data_from_host  in  16  write data from host.
- otg_hpi_data_to_host  out  16  registered read data.
- mbx_in_valid  out  1  host-to-local mailbox full.
- mbx_in_data  out  16  host-to-local mailbox value.
- mbx_in_ack  in  1  local side consumes the in-mailbox.
- mbx_out_valid  in  1  local side offers a word to the host.
- mbx_out_data  in  16  word offered by the local side.
- mbx_out_ready  out  1  = !out_full; the offer is accepted when valid & ready.

Behaviour:
- Asynchronous reset (reset_reset_n=0) clears:
  - data_to_host=0, addr_reg=0, in_full=0, out_full=0, mbx registers=0.
  - err=0, ovr=0, STATUS=RESET_STATUS.
  - RAM contents are not cleared.
- otg_hpi_reset_n=0 for a cycle clears the same state synchronously. Any access in progress is dropped and no commit happens.
- Access start:
  - read_start = cs_n=0 & r_n=0 this cycle, and not both true the previous cycle.
  - write_start is the same with w_n.
  - Each strobe assertion produces exactly one action, however long the strobe is held.
- cs_n=0 with r_n=0 and w_n=0 together: no action; sets sticky err (STATUS bit2).
- Write actions, committed on the write_start cycle using the data sampled that cycle:
  - DATA: RAM[addr_reg] <= data; addr_reg <= addr_reg+1, wrapping modulo 2^AW.
  - MAILBOX: in_data <= data; in_full <= 1. If in_full was already 1 and not acked the same cycle, set sticky ovr (bit3).
  - ADDRESS: addr_reg <= data[AW-1:0]; the upper bits are ignored.
  - STATUS: a write-1-to-clear on bits 2 and 3; other bits are ignored.
- Read actions:
  - data_to_host is valid on the cycle after read_start and holds until the next read.
  - DATA: returns RAM[addr_reg] using the pre-increment address, then addr_reg increments and wraps.
  - MAILBOX: returns out_data; out_full <= 0.
  - ADDRESS: returns addr_reg zero-extended to 16 bits.
  - STATUS: {12'b0, ovr, err, in_full, out_full}.
- Local mailbox:
  - mbx_in_ack while in_full clears in_full next cycle.
  - An ack while empty is ignored.
- Simultaneous events:
  - Host MAILBOX read and local push (mbx_out_valid & mbx_out_ready) cannot collide, since ready=0 while full.
  - Host read clearing out_full and a push on the following cycle is accepted normally.
  - Host MAILBOX write on the same cycle as mbx_in_ack: the new data wins, in_full stays 1, ovr is not set.
- Reset mid-access (either reset): the strobe history is cleared. A strobe still held low after reset release counts as a new start.

Optional Feature:
- HPI_TARGET_IRQ_EN defined:
  - Adds output hpi_irq (1 bit, reset 0).
  - hpi_irq is registered and equals out_full | ovr, one cycle after either changes.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package hpi_pkg holds:
  - Register-select enum (HPI_DATA=2'd0, HPI_MAILBOX=2'd1, HPI_ADDR=2'd2, HPI_STATUS=2'd3).
  - STATUS bit index constants (OUT_FULL=0, IN_FULL=1, ERR=2, OVR=3).
- One sub-module, hpi_target_ram: single-port 16-bit synchronous RAM, depth 2^AW, registered read, parameterised AW.

Test Plan:
1. Write ADDRESS=0x0005, then DATA writes 0x1111 and 0x2222, then ADDRESS=0x0005 and two DATA reads -> returns 0x1111 then 0x2222; ADDRESS reads 0x0007.
2. With AW=10: ADDRESS=0x03FF, DATA write 0xBEEF -> ADDRESS reads 0x0000 (wrap); reading back at 0x03FF returns 0xBEEF.
3. Host MAILBOX write 0xA5A5 -> mbx_in_valid=1, mbx_in_data=0xA5A5, STATUS=0x0002. A second write before ack -> STATUS=0x000A. Ack, then STATUS write 0x0008 -> STATUS=0x0000.
4. Local push 0x1234 -> mbx_out_ready=0, STATUS bit0=1 (hpi_irq=1 if HPI_TARGET_IRQ_EN). Host MAILBOX read -> 0x1234, out_full=0, ready=1.
5. r_n and w_n both low with cs_n low -> no RAM/address change, STATUS=0x0004. Hold a read strobe for 5 cycles on DATA -> addr_reg increments exactly once.
6. Pulse otg_hpi_reset_n low mid-sequence with in_full=1 and addr_reg=0x0042 -> STATUS=0x0000 and ADDRESS=0x0000 next read; RAM contents preserved.
